// File: rtl/sd_link_pkg.sv
// Shared constants for the SD command-line link (parallel_serial / serial_parallel).
package sd_link_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] CRC7_POLY  = 7'h09;
  localparam int         SD_FRAME_W = 48;
  localparam logic       START_BIT  = 1'b0;
  localparam logic       TX_BIT     = 1'b1;
  localparam logic       END_BIT    = 1'b1;
  localparam logic       IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7+x^3+1, init 0) with synchronous clear and a shift-out path.
module crc7_serial
  import sd_link_pkg::*;
(
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic       valid_i,
  input  logic       data_i,
  input  logic       shift_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d, base;
  logic       fb;

  always_comb begin
    base  = clear_i ? 7'd0 : crc_q;
    fb    = data_i ^ base[6];
    crc_d = base;
    if (valid_i) begin
      crc_d = {base[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    end else if (shift_i) begin
      crc_d = {base[5:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/parallel_serial.sv
// Parallel-to-serial SD command transmitter, MSB first, line idles high.
// Optional CRC7 insertion in bits 7..1 plus forced end bit: define PARALLEL_SERIAL_CRC7_EN.
module parallel_serial
  import sd_link_pkg::*;
#(
  parameter int WIDTH = SD_FRAME_W,
  parameter int CNT_W = 6
) (
  input  logic             iClock_SD,
  input  logic             iReset,
  input  logic             iEnable,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iParallel,
  output logic             oSerial,
  output logic             oBusy,
  output logic             oComplete
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic               ser_q, ser_d;
  logic               busy_q, busy_d;
  logic               cmp_q, cmp_d;
  logic               accept;
  logic               next_bit;

`ifdef PARALLEL_SERIAL_CRC7_EN
  logic [6:0] crc_w;
  logic [2:0] crc_idx;
  logic       crc_valid;
  logic       crc_clear;
  logic       crc_data;

  // The CRC is fed each data bit as it is loaded onto the line, so it is
  // complete by the time bit 7 is loaded.
  assign crc_clear = iReset | accept;
  assign crc_valid = ~iReset & (accept | ((state_q == S_SHIFT) & iEnable & (cnt_q > CNT_W'(8))));
  assign crc_data  = accept ? iParallel[WIDTH-1] : sh_q[WIDTH-2];
  assign crc_idx   = 3'(cnt_q - CNT_W'(2));

  crc7_serial u_crc (
    .clk_i  (iClock_SD),
    .clear_i(crc_clear),
    .valid_i(crc_valid),
    .data_i (crc_data),
    .shift_i(1'b0),
    .crc_o  (crc_w)
  );

  always_comb begin
    next_bit = sh_q[WIDTH-2];
    if (cnt_q == CNT_W'(1))       next_bit = END_BIT;
    else if (cnt_q <= CNT_W'(8))  next_bit = crc_w[crc_idx];
  end
`else
  assign next_bit = sh_q[WIDTH-2];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ser_d   = ser_q;
    busy_d  = busy_q;
    cmp_d   = cmp_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ser_d  = IDLE_LEVEL;
        busy_d = 1'b0;
        cmp_d  = 1'b0;
        accept = iEnable & iLoad;
      end
      S_SHIFT: begin
        if (iEnable) begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
            ser_d   = IDLE_LEVEL;
            busy_d  = 1'b0;
            cmp_d   = 1'b1;
          end else begin
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            ser_d = next_bit;
          end
        end
      end
      S_DONE: begin
        // oComplete stays up while disabled so the pulse is never missed.
        if (iEnable) begin
          state_d = S_IDLE;
          cmp_d   = 1'b0;
          ser_d   = IDLE_LEVEL;
          accept  = iLoad;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = S_SHIFT;
      sh_d    = iParallel;
      cnt_d   = CNT_W'(WIDTH - 1);
      ser_d   = iParallel[WIDTH-1];
      busy_d  = 1'b1;
      cmp_d   = 1'b0;
    end
  end

  always_ff @(posedge iClock_SD) begin
    if (iReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ser_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      cmp_q   <= cmp_d;
    end
  end

  assign oSerial   = ser_q;
  assign oBusy     = busy_q;
  assign oComplete = cmp_q;

endmodule

// File: tb/tb_parallel_serial.sv
// Directed self-checking bench for parallel_serial (table vectors + frame sequences).
module tb_parallel_serial;

  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst, en, ld;
  logic [W-1:0] par;
  logic         ser, busy, cmp;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  parallel_serial #(.WIDTH(W), .CNT_W(6)) dut (
    .iClock_SD(clk),
    .iReset   (rst),
    .iEnable  (en),
    .iLoad    (ld),
    .iParallel(par),
    .oSerial  (ser),
    .oBusy    (busy),
    .oComplete(cmp)
  );

  typedef struct {
    logic         rst;
    logic         en;
    logic         ld;
    logic [W-1:0] par;
    logic         ser;
    logic         busy;
    logic         cmp;
    string        name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line contents: CRC computed as remainder of M(x)*x^7 mod G(x).
  function automatic logic [W-1:0] exp_stream(input logic [W-1:0] f);
`ifdef PARALLEL_SERIAL_CRC7_EN
    logic [46:0] r;
    r = {f[47:8], 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'(8'h89) << (i - 7));
    return {f[47:8], r[6:0], 1'b1};
`else
    return f;
`endif
  endfunction

  task automatic start_load(input logic [W-1:0] f);
    en  = 1'b1;
    ld  = 1'b1;
    par = f;
    tick();
    ld  = 1'b0;
    par = ~f;
  endtask

  // Called in the first-bit cycle; walks the frame, then checks the DONE cycle.
  task automatic stream_frame(input logic [W-1:0] f, input logic [W-1:0] expv,
                              input int hold_at, input int hold_n, input int reload_at,
                              input logic chain, input logic [W-1:0] chain_f);
    logic [W-1:0] rx;
    rx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      int slots;
      slots = (i == hold_at) ? hold_n + 1 : 1;
      for (int s = 0; s < slots; s++) begin
        chk("serial_bit", ser, expv[i]);
        chk("busy_in_frame", busy, 1);
        chk("no_early_complete", cmp, 0);
        if (s == 0) rx = {rx[W-2:0], ser};
        en = (s < slots - 1) ? 1'b0 : 1'b1;
        if (i == reload_at && s == 0) begin
          ld  = 1'b1;
          par = ~f;
        end
        tick();
        ld = 1'b0;
      end
    end
    chk("rx_word", rx, expv);
    chk("done_complete", cmp, 1);
    chk("done_busy", busy, 0);
    chk("done_serial", ser, 1);
    if (chain) begin
      ld  = 1'b1;
      par = chain_f;
    end
    tick();
    ld = 1'b0;
    if (!chain) begin
      chk("complete_one_cycle", cmp, 0);
      chk("idle_high_after", ser, 1);
    end
  endtask

  initial begin
    logic [W-1:0] fa, fb, fc;
    rst = 1'b1;
    en  = 1'b1;
    ld  = 1'b0;
    par = '0;

    for (int i = 0; i < 3; i++)  tbl.push_back('{1, 1, 0, 48'h0, 1, 0, 0, "reset"});
    for (int i = 0; i < 10; i++) tbl.push_back('{0, 1, 0, 48'h0, 1, 0, 0, "idle"});
    tbl.push_back('{0, 0, 1, 48'h7000_0000_0000, 1, 0, 0, "load_while_disabled"});
    tbl.push_back('{0, 1, 1, 48'h7000_0000_0000, 0, 1, 0, "accept_msb"});
    tbl.push_back('{0, 0, 1, 48'hFFFF_FFFF_FFFF, 0, 1, 0, "hold_enable_low"});
    tbl.push_back('{0, 1, 0, 48'h0, 1, 1, 0, "bit46"});
    tbl.push_back('{0, 1, 0, 48'h0, 1, 1, 0, "bit45"});
    tbl.push_back('{1, 1, 0, 48'h0, 1, 0, 0, "reset_abort"});
    for (int i = 0; i < 2; i++)  tbl.push_back('{0, 1, 0, 48'h0, 1, 0, 0, "idle_after_abort"});

    foreach (tbl[k]) begin
      rst = tbl[k].rst;
      en  = tbl[k].en;
      ld  = tbl[k].ld;
      par = tbl[k].par;
      tick();
      chk({tbl[k].name, "_serial"},   ser,  tbl[k].ser);
      chk({tbl[k].name, "_busy"},     busy, tbl[k].busy);
      chk({tbl[k].name, "_complete"}, cmp,  tbl[k].cmp);
    end
    rst = 1'b0;
    ld  = 1'b0;
    en  = 1'b1;

    // Basic frame
    fa = 48'h48_0000_01AA_87;
    start_load(fa);
    stream_frame(fa, exp_stream(fa), -1, 0, -1, 1'b0, '0);

    // Bit 20 stretched by 5 disabled cycles
    start_load(fa);
    stream_frame(fa, exp_stream(fa), 20, 5, -1, 1'b0, '0);

    // Re-pulse while busy, then back-to-back load in DONE
    fa = 48'hA5A5_A5A5_A5A5;
    fb = 48'h5A5A_5A5A_5A5A;
    start_load(fa);
    stream_frame(fa, exp_stream(fa), -1, 0, 10, 1'b1, fb);
    stream_frame(fb, exp_stream(fb), -1, 0, -1, 1'b0, '0);

    // Reset while bit 30 is on the line
    fc = 48'hC3C3_0F0F_F00F;
    start_load(fc);
    for (int k = 0; k < W - 1 - 30; k++) tick();
    chk("bit30_before_reset", ser, exp_stream(fc) >> 30 & 48'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mid_serial", ser, 1);
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_complete", cmp, 0);
    for (int k = 0; k < 52; k++) begin
      tick();
      chk("no_complete_after_abort", cmp, 0);
    end
    start_load(fb);
    stream_frame(fb, exp_stream(fb), -1, 0, -1, 1'b0, '0);

`ifdef PARALLEL_SERIAL_CRC7_EN
    start_load(48'h40_0000_0000_00);
    stream_frame(48'h40_0000_0000_00, 48'h40_0000_0000_95, -1, 0, -1, 1'b0, '0);
    start_load(48'h48_0000_01AA_00);
    stream_frame(48'h48_0000_01AA_00, 48'h48_0000_01AA_87, -1, 0, -1, 1'b0, '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parallel_serial.md
Name: parallel_serial

Overview:
- Transmit-side counterpart of the serial_parallel receiver; frames go out on the SD command line.
- Captures one WIDTH-bit parallel frame (a 48-bit SD command by default) on a load strobe.
- Shifts the frame out MSB-first, one bit per iClock_SD cycle, then signals completion.
- Sits between the command-builder logic and the SD CMD pad; its oSerial output drives serial_parallel's iSerial in loopback benches.

Parameters:
- WIDTH, 48: frame length in bits; legal range 16..64.
- CNT_W, 6: bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- iClock_SD  input  1  single clock; all logic rises on its posedge.
- iReset  input  1  synchronous, active-high reset.
- iEnable  input  1  global enable; low freezes shifting, and iLoad is ignored while low.
- iLoad  input  1  one-cycle strobe; requests transmission of iParallel.
- iParallel  input  WIDTH  frame to send; sampled only in the cycle a load is accepted.
- oSerial  output  1  serial data; idles high.
- oBusy  output  1  high from the cycle after acceptance through the last bit.
- oComplete  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset: synchronous on the iClock_SD posedge while iReset=1.
  - Values: oSerial=1, oBusy=0, oComplete=0, state=IDLE, counter=0, shift register=0.
  - Reset overrides every other input, including mid-frame: the frame aborts, no oComplete is issued, and the line returns high the next cycle.
- State IDLE:
  - Outputs: oSerial=1, oBusy=0.
  - If iEnable=1 and iLoad=1: capture iParallel, set counter=WIDTH-1, go to SHIFT.
- State SHIFT:
  - First SHIFT cycle (the cycle after acceptance): oSerial=iParallel[WIDTH-1].
  - Each following enabled cycle: shift left by one and decrement the counter.
  - Every bit is held exactly one enabled cycle.
  - When the counter is 0 and iEnable=1: go to DONE.
- State DONE (one cycle):
  - Outputs: oComplete=1, oSerial=1, oBusy=0; then go to IDLE.
  - Back-to-back: a load accepted during DONE starts the next frame immediately, i.e. IDLE is skipped and the next frame begins the following cycle.
- Latency:
  - Strobe cycle N → first bit at N+1, last bit at N+WIDTH, oComplete at N+WIDTH+1.
  - This assumes iEnable stays high.
- iEnable low during SHIFT:
  - oSerial, the counter and the shift register all hold; oBusy stays 1.
  - Each low cycle stretches the current bit by one cycle.
- iEnable low during DONE: DONE is held and oComplete is deferred until iEnable returns high, so oComplete is never lost.
- iLoad while oBusy=1: ignored; the in-flight frame is not corrupted.
- iParallel changing after acceptance: no effect, because the frame is captured at acceptance.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: PARALLEL_SERIAL_CRC7_EN.
- Defined:
  - A serial CRC7 (polynomial x^7+x^3+1, initial value 0) accumulates bits WIDTH-1 down to 8 as they are transmitted.
  - During bit slots 7..1, the CRC register is shifted out MSB-first in place of iParallel[7:1].
  - Bit 0 is forced to 1 (end bit).
  - iParallel[7:0] is ignored.
  - The CRC resets at acceptance and on iReset.
- Not defined: all WIDTH bits are sent verbatim and no CRC logic is synthesised.

Decomposition:
- Shared package sd_link_pkg:
  - State encoding constants S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
  - CRC7_POLY=7'h09.
  - SD_FRAME_W=48.
  - Start/transmit bit constants.
- Sub-module crc7_serial:
  - Inputs: clock, synchronous clear, bit-valid, data bit.
  - Output: 7-bit CRC with shift-out control.
  - Instantiated only under PARALLEL_SERIAL_CRC7_EN; the serial_parallel receiver can reuse it for checking.

Test Plan:
1. Reset/idle: hold iReset 3 cycles, then release with iLoad=0 → oSerial=1, oBusy=0, oComplete=0 for 10 cycles.
2. Basic frame: iParallel=48'h48_000001AA_87, iLoad pulse at cycle N → oSerial reproduces the frame MSB-first during N+1..N+48; oComplete=1 only at N+49. Loopback into serial_parallel gives oParallel=48'h48000001AA87.
3. Enable gating: same frame, iEnable low for 5 cycles mid-frame at bit 20 → bit 20 is held 6 cycles; oComplete at N+54; received word unchanged.
4. Busy protection and back-to-back: frame A=48'hA5A5A5A5A5A5 with iLoad re-pulsed at bit 10 using frame B → the re-pulse is ignored and A is intact. Then B=48'h5A5A5A5A5A5A loaded in the DONE cycle → B's MSB appears the next cycle, with no idle-high gap.
5. Reset mid-frame: iReset at bit 30 → oSerial=1 and oBusy=0 the next cycle; no oComplete. A fresh frame then transmits correctly.
6. CRC (macro defined): iParallel=48'h40_00000000_00 → transmitted stream is 48'h400000000095. iParallel=48'h48_000001AA_00 → stream is 48'h48000001AA87.
